spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI target (slave) transceiver: the far end of the SPI master link, used where the Bexkat1 SoC is driven by an external SPI host (debug/boot-load path).
- Oversamples the external sclk/ss_n/mosi in the system clock domain and exchanges one byte per 8 sclk cycles.
- Receives into a hold register, transmits from a hold register, and drives miso with an output enable for the pad tristate.
- Mode (cpol/cpha) comes from the same conf word layout the SPI master uses.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sclk, ss_n and mosi (minimum 2).
- IDLE_FILL, 8'hFF, byte shifted out when no tx byte is loaded (underrun).

Ports:
- clock  input  1  system clock; must run at ≥6× sclk.
- reset  input  1  synchronous, active-high reset.
- conf  input  16  [1]=cpol, [0]=cpha; other bits ignored; sampled only while ss_n (synced) is high.
- tx  input  8  byte to send next.
- tx_load  input  1  write tx to tx hold; ignored when tx_ready=0.
- tx_ready  output  1  tx hold empty.
- rx  output  8  received byte (hold or FIFO head).
- rx_valid  output  1  rx holds unread data.
- rx_ack  input  1  consume rx; ignored when rx_valid=0.
- clear_flags  input  1  clears overrun/underrun.
- overrun  output  1  sticky; received byte arrived with no room.
- underrun  output  1  sticky; byte started with tx hold empty.
- busy  output  1  synced ss_n low.
- ss_n  input  1  async target select, active low.
- sclk  input  1  async SPI clock.
- mosi  input  1  async data in.
- miso  output  1  data out = shift register MSB.
- miso_oe  output  1  pad enable = busy.

Behaviour:
- Reset: rx=0, rx_valid=0, tx_ready=1, overrun=0, underrun=0, busy=0, miso_oe=0, shift register=IDLE_FILL (miso=1), bit count=0.
- Synchronizers: SYNC_STAGES flops, then one edge-detect flop. A pin change is acted on at clock edge SYNC_STAGES+1 after it.
- Leading edge = synced sclk leaving cpol level; trailing edge = returning to it.
- States:
  - IDLE: synced ss_n high.
  - LOAD: one cycle after ss_n falls. Shift register ← tx hold (tx_ready→1 next cycle) or IDLE_FILL (underrun←1). Bit count←0. conf is latched here.
  - SHIFT: runs until ss_n rises.
- cpha=0:
  - MSB is on miso from LOAD.
  - Sample mosi into LSB on the leading edge; shift left on the trailing edge.
  - After the 8th sample the byte is complete.
  - The 8th trailing edge reloads the shift register (tx hold or IDLE_FILL, same rules as LOAD) instead of shifting.
- cpha=1:
  - Shift out on the leading edge. The first leading edge of each byte presents the MSB; no shift occurs on it.
  - Sample on the trailing edge; the 8th trailing sample completes the byte.
  - The next leading edge reloads the shift register.
- Byte complete: the byte is written to rx in the cycle after the completing sample.
  - If rx_valid=0, or rx_ack is asserted in that same cycle: rx←byte, rx_valid=1.
  - Otherwise: overrun←1 and rx is overwritten.
- rx_ack with rx_valid=1 and no completion in that cycle: rx_valid←0 next cycle.
- tx_load with tx_ready=1: tx hold←tx, tx_ready←0 next cycle.
  - tx_load in the same cycle as a reload: the reload takes the old hold contents (or IDLE_FILL); the new byte stays in hold.
- ss_n rising mid-byte:
  - Abort; partial bits are discarded; no rx_valid.
  - A tx byte already moved into the shift register is lost.
  - Return to IDLE; miso_oe=0 next cycle.
- clear_flags coinciding with a flag set: set wins.
- conf changes while busy=1 are ignored until the next frame.

Optional Feature:
- Macro SPI_TARGET_RXFIFO_EN.
- Defined: received bytes go into a 4-entry FIFO.
  - rx = head, rx_valid = not empty, rx_ack pops.
  - A completion while full (and no pop that cycle) drops the new byte and sets overrun. Push and pop in the same cycle when full succeed.
  - reset empties the FIFO.
- Undefined: single hold register with the overwrite behaviour above.

Test Plan:
- Mode 0, tx_load 8'hA5, host sends 8'h3C at clock/8 → miso bits 1,0,1,0,0,1,0,1; rx=8'h3C; rx_valid=1; underrun=0.
- Mode 3, two-byte frame, tx 8'h81 then 8'h7E loaded on tx_ready, host sends 8'h12,8'h34 → host reads 8'h81,8'h7E; rx 8'h12 then 8'h34 (acked between bytes).
- No tx_load, mode 1, host sends 8'h55 → host reads 8'hFF; underrun=1; rx=8'h55. clear_flags → underrun=0.
- Without FIFO, two bytes 8'h01,8'h02, no rx_ack → rx=8'h02, overrun=1. With SPI_TARGET_RXFIFO_EN, six bytes, no ack → bytes 1–4 are read back in order, overrun=1.
- ss_n rises after 5 sclk cycles → rx_valid stays 0, miso_oe=0; next full frame 8'hC3 is received correctly.
- reset asserted mid-frame → all outputs return to reset values next cycle; a subsequent frame works.

Source files
------------

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
//  Module   : spi_target
//  Purpose  : SPI target transceiver. Oversamples sclk/ss_n/mosi in the system
//             clock domain and exchanges one byte per 8 sclk cycles.
//             Define SPI_TARGET_RXFIFO_EN for a 4-entry receive FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] conf,
    input  logic [7:0]  tx,
    input  logic        tx_load,
    output logic        tx_ready,
    output logic [7:0]  rx,
    output logic        rx_valid,
    input  logic        rx_ack,
    input  logic        clear_flags,
    output logic        overrun,
    output logic        underrun,
    output logic        busy,
    input  logic        ss_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_cpol;
    logic       r_cpha;
    logic [7:0] r_shift;
    logic [3:0] r_cnt;
    logic       r_sample;
    logic       r_fill_pend;
    logic       r_done;
    logic [7:0] r_byte;
    logic [7:0] r_tx_hold;
    logic       r_tx_ready;
    logic       r_overrun;
    logic       r_underrun;

    logic       w_sclk_s;
    logic       w_ss_s;
    logic       w_mosi_s;
    logic       w_lead;
    logic       w_trail;
    logic       w_active;
    logic       w_reload_now;
    logic       w_shift_now;
    logic       w_sample_now;
    logic       w_complete;
    logic       w_fill_now;
    logic       w_defer;
    logic       w_under_set;
    logic       w_over_set;
    logic [7:0] w_reload_data;
    logic       w_unused_conf;

    assign w_unused_conf = ^conf[15:2];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
    assign w_lead  = (w_sclk_s ^ r_sclk_d) && (w_sclk_s != r_cpol);
    assign w_trail = (w_sclk_s ^ r_sclk_d) && (w_sclk_s == r_cpol);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (!w_ss_s) w_state_next = c_LOAD;
            c_LOAD:  w_state_next = w_ss_s ? c_IDLE : c_SHIFT;
            c_SHIFT: if (w_ss_s) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // r_cnt counts samples of the current byte; 8 means "complete, reload due".
    assign w_active      = (r_state == c_SHIFT) && !w_ss_s;
    assign w_reload_now  = ((r_state == c_LOAD) && !w_ss_s) ||
                           (w_active && (r_cnt == 4'd8) && (r_cpha ? w_lead : w_trail));
    assign w_shift_now   = w_active && (r_cpha ? (w_lead && (r_cnt != 4'd0) && (r_cnt != 4'd8))
                                               : (w_trail && (r_cnt != 4'd8)));
    assign w_sample_now  = w_active && (r_cnt != 4'd8) && (r_cpha ? w_trail : w_lead);
    assign w_complete    = w_sample_now && (r_cnt == 4'd7);
    assign w_reload_data = r_tx_ready ? IDLE_FILL : r_tx_hold;

    // In cpha=0 the reload happens at the end of the previous byte, so the
    // underrun is only flagged once the next byte actually begins.
    assign w_fill_now  = w_reload_now && r_tx_ready;
    assign w_defer     = (r_state == c_SHIFT) && !r_cpha;
    assign w_under_set = (w_fill_now && !w_defer) ||
                         (w_active && !r_cpha && w_lead && r_fill_pend);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_shift     <= IDLE_FILL;
            r_cnt       <= 4'd0;
            r_sample    <= 1'b0;
            r_fill_pend <= 1'b0;
            r_done      <= 1'b0;
            r_byte      <= 8'h00;
        end else begin
            if ((r_state == c_IDLE) && w_ss_s) begin
                r_cpol <= conf[1];
                r_cpha <= conf[0];
            end

            if ((r_state != c_IDLE) && w_ss_s) begin
                r_shift <= IDLE_FILL;
            end else if (w_reload_now) begin
                r_shift <= w_reload_data;
            end else if (w_shift_now) begin
                r_shift <= {r_shift[6:0], r_sample};
            end

            if (w_ss_s || w_reload_now) begin
                r_cnt <= 4'd0;
            end else if (w_sample_now) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_sample_now) begin
                r_sample <= w_mosi_s;
            end

            if ((r_state != c_SHIFT) || w_ss_s) begin
                r_fill_pend <= 1'b0;
            end else if (w_fill_now && w_defer) begin
                r_fill_pend <= 1'b1;
            end else if (w_lead) begin
                r_fill_pend <= 1'b0;
            end

            r_done <= w_complete;
            if (w_complete) begin
                r_byte <= {r_shift[6:0], w_mosi_s};
            end
        end
    end

    // A reload and a new tx_load cannot both touch r_tx_ready: one needs it
    // clear, the other set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_hold  <= 8'h00;
            r_tx_ready <= 1'b1;
        end else if (tx_load && r_tx_ready) begin
            r_tx_hold  <= tx;
            r_tx_ready <= 1'b0;
        end else if (w_reload_now && !r_tx_ready) begin
            r_tx_ready <= 1'b1;
        end
    end

`ifdef SPI_TARGET_RXFIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       w_pop;
    logic       w_push;

    assign w_pop      = rx_ack && (r_count != 3'd0);
    assign w_push     = r_done && ((r_count != 3'd4) || w_pop);
    assign w_over_set = r_done && !w_push;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_byte;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    assign rx       = r_fifo[r_rd_ptr];
    assign rx_valid = (r_count != 3'd0);
`else
    logic [7:0] r_rx;
    logic       r_rx_valid;

    assign w_over_set = r_done && r_rx_valid && !rx_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx       <= 8'h00;
            r_rx_valid <= 1'b0;
        end else if (r_done) begin
            r_rx       <= r_byte;
            r_rx_valid <= 1'b1;
        end else if (rx_ack && r_rx_valid) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx       = r_rx;
    assign rx_valid = r_rx_valid;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_over_set) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_under_set) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;
    assign busy     = !r_ss_d;
    assign miso_oe  = !r_ss_d;
    assign miso     = r_shift[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_target
//  Purpose  : Self-checking bench for spi_target; the bench acts as SPI host.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] conf = 16'h0000;
    logic [7:0]  tx = 8'h00;
    logic        tx_load = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx;
    logic        rx_valid;
    logic        rx_ack = 1'b0;
    logic        clear_flags = 1'b0;
    logic        overrun;
    logic        underrun;
    logic        busy;
    logic        ss_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;

    spi_target dut (
        .clock       (clock),
        .reset       (reset),
        .conf        (conf),
        .tx          (tx),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx          (rx),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .clear_flags (clear_flags),
        .overrun     (overrun),
        .underrun    (underrun),
        .busy        (busy),
        .ss_n        (ss_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       do_load;
        logic [7:0] txb;
        logic [7:0] host;
        logic [7:0] exp_miso;
        logic       exp_under;
    } vec_t;

    vec_t vecs [4];

    logic [7:0] hq [$];
    logic [7:0] got;
    logic [7:0] hb;
    logic [7:0] exp_b;
    logic [7:0] nb_tx;
    logic       cp, ch, pre, mid, exp_under;
    int         nb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        conf = {14'h0, cpol, cpha};
        sclk = cpol;
        cyc(6);
    endtask

    task automatic frame_start();
        ss_n = 1'b0;
        cyc(8);
    endtask

    task automatic frame_end();
        cyc(4);
        ss_n = 1'b1;
        cyc(8);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx = b;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        cyc(1);
    endtask

    task automatic clr();
        clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        cyc(1);
    endtask

    // Host side: 4 system clocks per sclk half period (clock/8).
    task automatic xfer_bits(input logic cpol, input logic cpha, input logic [7:0] din,
                             input int nbits, output logic [7:0] dout);
        dout = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            int i;
            i = 7 - k;
            if (!cpha) begin
                mosi = din[i];
                cyc(4);
                dout[i] = miso;
                sclk = ~cpol;
                cyc(4);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = din[i];
                cyc(4);
                dout[i] = miso;
                sclk = cpol;
                cyc(4);
            end
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 8'hFF, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h96, 8'hE1, 8'h96, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0, 8'h0F, 1'b0};

        cyc(3);
        chk("reset_rx", rx, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_tx_ready", tx_ready, 1'b1);
        chk("reset_flags", {overrun, underrun}, 2'b00);
        chk("reset_busy_oe", {busy, miso_oe}, 2'b00);
        chk("reset_miso", miso, 1'b1);
        reset = 1'b0;
        cyc(4);

        // Single-byte frames, one per mode.
        for (int v = 0; v < 4; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha);
            if (vecs[v].do_load) load_tx(vecs[v].txb);
            frame_start();
            chk("frame_busy_oe", {busy, miso_oe}, 2'b11);
            xfer_bits(vecs[v].cpol, vecs[v].cpha, vecs[v].host, 8, got);
            frame_end();
            chk("vec_miso_byte", got, vecs[v].exp_miso);
            chk("vec_rx", rx, vecs[v].host);
            chk("vec_rx_valid", rx_valid, 1'b1);
            chk("vec_underrun", underrun, vecs[v].exp_under);
            chk("vec_overrun", overrun, 1'b0);
            chk("vec_tx_ready", tx_ready, 1'b1);
            chk("vec_idle_oe", miso_oe, 1'b0);
            ack();
            chk("vec_rx_acked", rx_valid, 1'b0);
            clr();
            chk("vec_flags_cleared", underrun, 1'b0);
        end

        // Mode 3 two-byte frame, second tx byte loaded once hold frees up.
        set_mode(1'b1, 1'b1);
        load_tx(8'h81);
        frame_start();
        chk("m3_tx_ready_after_load", tx_ready, 1'b1);
        load_tx(8'h7E);
        xfer_bits(1'b1, 1'b1, 8'h12, 8, got);
        chk("m3_miso0", got, 8'h81);
        chk("m3_rx0", rx, 8'h12);
        ack();
        xfer_bits(1'b1, 1'b1, 8'h34, 8, got);
        chk("m3_miso1", got, 8'h7E);
        chk("m3_rx1", rx, 8'h34);
        frame_end();
        chk("m3_flags", {overrun, underrun}, 2'b00);
        ack();

        // Unacknowledged back-to-back bytes.
        set_mode(1'b0, 1'b0);
        clr();
`ifdef SPI_TARGET_RXFIFO_EN
        frame_start();
        for (int b = 1; b <= 6; b++) xfer_bits(1'b0, 1'b0, 8'(b), 8, got);
        frame_end();
        chk("fifo_overrun", overrun, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            chk("fifo_valid", rx_valid, 1'b1);
            chk("fifo_order", rx, 8'(b));
            ack();
        end
        chk("fifo_empty", rx_valid, 1'b0);
`else
        frame_start();
        xfer_bits(1'b0, 1'b0, 8'h01, 8, got);
        xfer_bits(1'b0, 1'b0, 8'h02, 8, got);
        frame_end();
        chk("ovr_rx", rx, 8'h02);
        chk("ovr_valid", rx_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        ack();
`endif
        clr();
        chk("ovr_cleared", overrun, 1'b0);

        // Abort after 5 sclk cycles, then a clean frame.
        frame_start();
        xfer_bits(1'b0, 1'b0, 8'hAA, 5, got);
        frame_end();
        chk("abort_rx_valid", rx_valid, 1'b0);
        chk("abort_oe", miso_oe, 1'b0);
        chk("abort_miso_idle", miso, 1'b1);
        frame_start();
        xfer_bits(1'b0, 1'b0, 8'hC3, 8, got);
        frame_end();
        chk("post_abort_rx", rx, 8'hC3);
        chk("post_abort_valid", rx_valid, 1'b1);
        ack();
        clr();

        // Random frames against a transaction-level model of the hold register.
        for (int f = 0; f < 24; f++) begin
            cp  = 1'($urandom_range(0, 1));
            ch  = 1'($urandom_range(0, 1));
            pre = 1'($urandom_range(0, 1));
            mid = 1'($urandom_range(0, 1));
            nb  = $urandom_range(1, 3);
            clr();
            set_mode(cp, ch);
            if (pre && hq.size() == 0) begin
                nb_tx = 8'($urandom);
                load_tx(nb_tx);
                hq.push_back(nb_tx);
            end
            exp_under = 1'b0;
            frame_start();
            for (int k = 0; k < nb; k++) begin
                if (hq.size() > 0) begin
                    exp_b = hq.pop_front();
                end else begin
                    exp_b = 8'hFF;
                    exp_under = 1'b1;
                end
                if (k == 0 && mid && hq.size() == 0) begin
                    nb_tx = 8'($urandom);
                    load_tx(nb_tx);
                    hq.push_back(nb_tx);
                end
                hb = 8'($urandom);
                xfer_bits(cp, ch, hb, 8, got);
                chk("rnd_miso", got, exp_b);
                chk("rnd_rx", rx, hb);
                ack();
            end
            // cpha=0 reloads at the last trailing edge; that byte is lost.
            if (!ch && hq.size() > 0) void'(hq.pop_front());
            frame_end();
            chk("rnd_underrun", underrun, exp_under);
            chk("rnd_tx_ready", tx_ready, hq.size() == 0);
            chk("rnd_overrun", overrun, 1'b0);
        end
        // Drain any leftover hold byte so later expectations start clean.
        if (hq.size() > 0) begin
            set_mode(1'b1, 1'b1);
            frame_start();
            frame_end();
            void'(hq.pop_front());
        end
        clr();

        // Reset in the middle of a frame.
        set_mode(1'b1, 1'b0);
        frame_start();
        xfer_bits(1'b1, 1'b0, 8'h77, 8, got);
        frame_end();
        frame_start();
        load_tx(8'h5A);
        xfer_bits(1'b1, 1'b0, 8'h11, 3, got);
        chk("pre_reset_state", {rx_valid, tx_ready, underrun, busy}, 4'b1011);
        reset = 1'b1;
        cyc(1);
        chk("mid_reset_rx", rx, 8'h00);
        chk("mid_reset_valid_ready", {rx_valid, tx_ready}, 2'b01);
        chk("mid_reset_flags", {overrun, underrun}, 2'b00);
        chk("mid_reset_busy_oe_miso", {busy, miso_oe, miso}, 3'b001);
        ss_n = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(4);
        set_mode(1'b1, 1'b0);
        load_tx(8'h3E);
        frame_start();
        xfer_bits(1'b1, 1'b0, 8'h9D, 8, got);
        frame_end();
        chk("post_reset_miso", got, 8'h3E);
        chk("post_reset_rx", rx, 8'h9D);
        chk("post_reset_flags", {overrun, underrun}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
